// File: rtl/score_arbiter_ctrl.sv
// Two-player score controller: latches point pulses, arbitrates one update
// at a time, drives the four BCD digit counters and detects the winner.
//
// Counter handshake: cnt_tick is the only qualifier. cnt_en is meaningful
// only in a cycle where cnt_tick=1, and the pair is held for exactly one cycle.
// There is no back-pressure; the digit counters must accept every tick.
module score_arbiter_ctrl #(
    parameter int TARGET_W = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [TARGET_W-1:0] target,
    input  logic                point_p1,
    input  logic                point_p2,
    output logic                cnt_clr,
    output logic                cnt_tick,
    output logic [3:0]          cnt_en,
    output logic [6:0]          score_p1,
    output logic [6:0]          score_p2,
    output logic                busy,
    output logic                game_over,
    output logic [1:0]          winner,
    output logic                ovf,
    output logic [1:0]          state
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_PLAY   = 2'd1;
    localparam logic [1:0] S_UPDATE = 2'd2;
    localparam logic [1:0] S_OVER   = 2'd3;

    // Player identifiers used by the grant and round-robin pointer.
    localparam logic PL_P1 = 1'b0;
    localparam logic PL_P2 = 1'b1;

    logic [1:0] state_q;
    logic [1:0] pend_q;
    logic       last_q;
    logic       grant_q;
    logic [6:0] target_q;

    logic [6:0] target_eff;
    logic [1:0] pts;
    logic       grant_now;
    logic       grant_sel;
    logic [1:0] clr_mask;
    logic [1:0] drop;
    logic [1:0] pend_next;
    logic [6:0] sel_score;
    logic       sel_nine;
    logic [6:0] upd_score;
    logic [6:0] upd_next;
    logic       win;

    assign state = state_q;
    assign pts   = {point_p2, point_p1};

    // Out-of-range targets (0 or above 99) fall back to 99.
    always_comb begin
        target_eff = 7'(target);
        if (target == '0 || 32'(target) > 32'd99) begin
            target_eff = 7'd99;
        end
    end

    // Round-robin grant, pending-flag update and drop detection.
    always_comb begin
        grant_now = (state_q == S_PLAY) && (pend_q != 2'b00);
        grant_sel = PL_P1;
        if (pend_q == 2'b11) begin
            grant_sel = (last_q == PL_P2) ? PL_P1 : PL_P2;
        end else if (pend_q[1]) begin
            grant_sel = PL_P2;
        end
        clr_mask = 2'b00;
        if (grant_now) begin
            clr_mask = (grant_sel == PL_P2) ? 2'b10 : 2'b01;
        end
        // A pulse on a flag that stays set is lost; a pulse coinciding
        // with that flag's grant simply re-arms it.
        drop      = pts & pend_q & ~clr_mask;
        pend_next = (pend_q & ~clr_mask) | pts;
        sel_score = (grant_sel == PL_P2) ? score_p2 : score_p1;
        sel_nine  = ((sel_score % 7'd10) == 7'd9);
        upd_score = (grant_q == PL_P2) ? score_p2 : score_p1;
        upd_next  = upd_score + 7'd1;
        win       = (upd_next == target_q);
    end

    // Match sequencing, counter strobes and shadow scores.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            pend_q    <= 2'b00;
            last_q    <= PL_P2;
            grant_q   <= PL_P1;
            target_q  <= 7'd99;
            cnt_clr   <= 1'b0;
            cnt_tick  <= 1'b0;
            cnt_en    <= 4'b0000;
            score_p1  <= 7'd0;
            score_p2  <= 7'd0;
            busy      <= 1'b0;
            game_over <= 1'b0;
            winner    <= 2'b00;
            ovf       <= 1'b0;
        end else begin
            cnt_clr  <= 1'b0;
            cnt_tick <= 1'b0;
            cnt_en   <= 4'b0000;
            busy     <= 1'b0;
            case (state_q)
                S_IDLE, S_OVER: begin
                    if (start) begin
                        state_q   <= S_PLAY;
                        cnt_clr   <= 1'b1;
                        score_p1  <= 7'd0;
                        score_p2  <= 7'd0;
                        pend_q    <= 2'b00;
                        winner    <= 2'b00;
                        ovf       <= 1'b0;
                        game_over <= 1'b0;
                        target_q  <= target_eff;
                    end
                end
                S_PLAY: begin
                    pend_q <= pend_next;
                    if (drop != 2'b00) begin
                        ovf <= 1'b1;
                    end
                    if (grant_now) begin
                        state_q  <= S_UPDATE;
                        grant_q  <= grant_sel;
                        last_q   <= grant_sel;
                        cnt_tick <= 1'b1;
                        busy     <= 1'b1;
                        // Tens digit carries when the units digit is about to wrap.
                        if (grant_sel == PL_P2) begin
                            cnt_en <= {sel_nine, 1'b1, 2'b00};
                        end else begin
                            cnt_en <= {2'b00, sel_nine, 1'b1};
                        end
                    end
                end
                S_UPDATE: begin
                    if (drop != 2'b00) begin
                        ovf <= 1'b1;
                    end
                    if (grant_q == PL_P2) begin
                        score_p2 <= upd_next;
                    end else begin
                        score_p1 <= upd_next;
                    end
                    if (win) begin
                        state_q   <= S_OVER;
                        game_over <= 1'b1;
                        winner    <= (grant_q == PL_P2) ? 2'b10 : 2'b01;
                        pend_q    <= 2'b00;
                    end else begin
                        state_q <= S_PLAY;
                        pend_q  <= pend_next;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
